// File: rtl/mem_stats_sequencer.sv
// Memory-port sequencer: reads a length-prefixed byte list, computes max/min/floor-average
// and optionally writes them back (define STATS_WRITEBACK_EN to enable the writeback states).
module mem_stats_sequencer (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       Start,
    input  logic [7:0] Base_addr,
    input  logic [7:0] Result_addr,
    input  logic [7:0] Mem_rdata,
    output logic [7:0] Mem_addr,
    output logic [7:0] Mem_wdata,
    output logic       Mem_write,
    output logic       Busy,
    output logic       Done,
    output logic       Err,
    output logic [7:0] Max_out,
    output logic [7:0] Min_out,
    output logic [7:0] Avg_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SCAN,
        S_DIV,
        S_WR_MAX,
        S_WR_MIN,
        S_WR_AVG,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  base_q, base_d;
    logic [7:0]  n_q, n_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  max_q, max_d;
    logic [7:0]  min_q, min_d;
    // sum_q is shifted left during DIV and ends up holding the quotient
    logic [15:0] sum_q, sum_d;
    logic [7:0]  rem_q, rem_d;
    logic        err_q, err_d;
    logic [7:0]  max_out_q, max_out_d;
    logic [7:0]  min_out_q, min_out_d;
    logic [7:0]  avg_out_q, avg_out_d;

    logic [8:0]  rem_shift;
    logic [7:0]  rem_sub;
    logic [7:0]  mem_addr_c;
    logic [7:0]  mem_wdata_c;
    logic        mem_write_c;

`ifdef STATS_WRITEBACK_EN
    logic [7:0]  res_q, res_d;
`else
    logic        unused_result_addr;
    assign unused_result_addr = ^Result_addr;
`endif

    // Restoring-divide step: remainder stays below N, so 8-bit subtraction is exact
    assign rem_shift = {rem_q, sum_q[15]};
    assign rem_sub   = rem_shift[7:0] - n_q;

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        n_d         = n_q;
        idx_d       = idx_q;
        max_d       = max_q;
        min_d       = min_q;
        sum_d       = sum_q;
        rem_d       = rem_q;
        err_d       = err_q;
        max_out_d   = max_out_q;
        min_out_d   = min_out_q;
        avg_out_d   = avg_out_q;
        mem_addr_c  = 8'h00;
        mem_wdata_c = 8'h00;
        mem_write_c = 1'b0;
`ifdef STATS_WRITEBACK_EN
        res_d       = res_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_LOAD;
                    base_d  = Base_addr;
                    err_d   = 1'b0;
`ifdef STATS_WRITEBACK_EN
                    res_d   = Result_addr;
`endif
                end
            end
            S_LOAD: begin
                mem_addr_c = base_q;
                n_d   = Mem_rdata;
                max_d = 8'h00;
                min_d = 8'hFF;
                sum_d = 16'h0000;
                rem_d = 8'h00;
                idx_d = 8'h00;
                if (Mem_rdata == 8'h00) begin
                    state_d   = S_DONE;
                    err_d     = 1'b1;
                    max_out_d = 8'h00;
                    min_out_d = 8'h00;
                    avg_out_d = 8'h00;
                end else begin
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                mem_addr_c = base_q + 8'd1 + idx_q;
                if (Mem_rdata > max_q) max_d = Mem_rdata;
                if (Mem_rdata < min_q) min_d = Mem_rdata;
                sum_d = sum_q + {8'h00, Mem_rdata};
                idx_d = idx_q + 8'd1;
                if (idx_q == n_q - 8'd1) begin
                    state_d = S_DIV;
                    idx_d   = 8'h00;
                end
            end
            S_DIV: begin
                if (rem_shift >= {1'b0, n_q}) begin
                    rem_d = rem_sub;
                    sum_d = {sum_q[14:0], 1'b1};
                end else begin
                    rem_d = rem_shift[7:0];
                    sum_d = {sum_q[14:0], 1'b0};
                end
                idx_d = idx_q + 8'd1;
                if (idx_q == 8'd15) begin
`ifdef STATS_WRITEBACK_EN
                    state_d = S_WR_MAX;
`else
                    state_d   = S_DONE;
                    max_out_d = max_q;
                    min_out_d = min_q;
                    avg_out_d = sum_d[7:0];
`endif
                end
            end
`ifdef STATS_WRITEBACK_EN
            S_WR_MAX: begin
                mem_write_c = 1'b1;
                mem_addr_c  = res_q;
                mem_wdata_c = max_q;
                state_d     = S_WR_MIN;
            end
            S_WR_MIN: begin
                mem_write_c = 1'b1;
                mem_addr_c  = res_q + 8'd1;
                mem_wdata_c = min_q;
                state_d     = S_WR_AVG;
            end
            S_WR_AVG: begin
                mem_write_c = 1'b1;
                mem_addr_c  = res_q + 8'd2;
                mem_wdata_c = sum_q[7:0];
                state_d     = S_DONE;
                max_out_d   = max_q;
                min_out_d   = min_q;
                avg_out_d   = sum_q[7:0];
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q   <= S_IDLE;
            base_q    <= 8'h00;
            n_q       <= 8'h00;
            idx_q     <= 8'h00;
            max_q     <= 8'h00;
            min_q     <= 8'h00;
            sum_q     <= 16'h0000;
            rem_q     <= 8'h00;
            err_q     <= 1'b0;
            max_out_q <= 8'h00;
            min_out_q <= 8'h00;
            avg_out_q <= 8'h00;
`ifdef STATS_WRITEBACK_EN
            res_q     <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            n_q       <= n_d;
            idx_q     <= idx_d;
            max_q     <= max_d;
            min_q     <= min_d;
            sum_q     <= sum_d;
            rem_q     <= rem_d;
            err_q     <= err_d;
            max_out_q <= max_out_d;
            min_out_q <= min_out_d;
            avg_out_q <= avg_out_d;
`ifdef STATS_WRITEBACK_EN
            res_q     <= res_d;
`endif
        end
    end

    // Memory strobes are decoded from state so reset removes them immediately
    assign Mem_addr  = mem_addr_c;
    assign Mem_wdata = mem_wdata_c;
    assign Mem_write = mem_write_c;
    assign Busy      = (state_q != S_IDLE);
    assign Done      = (state_q == S_DONE);
    assign Err       = err_q;
    assign Max_out   = max_out_q;
    assign Min_out   = min_out_q;
    assign Avg_out   = avg_out_q;

endmodule

// File: tb/tb_mem_stats_sequencer.sv
// Self-checking bench for mem_stats_sequencer: directed table, random lists against a
// list-level reference model, and reset / ignored-Start corner sequences.
module tb_mem_stats_sequencer;

`ifdef STATS_WRITEBACK_EN
    localparam bit WB = 1'b1;
`else
    localparam bit WB = 1'b0;
`endif

    logic       CLK;
    logic       RST_n;
    logic       Start;
    logic [7:0] Base_addr;
    logic [7:0] Result_addr;
    logic [7:0] Mem_rdata;
    logic [7:0] Mem_addr;
    logic [7:0] Mem_wdata;
    logic       Mem_write;
    logic       Busy;
    logic       Done;
    logic       Err;
    logic [7:0] Max_out;
    logic [7:0] Min_out;
    logic [7:0] Avg_out;

    mem_stats_sequencer dut (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .Start      (Start),
        .Base_addr  (Base_addr),
        .Result_addr(Result_addr),
        .Mem_rdata  (Mem_rdata),
        .Mem_addr   (Mem_addr),
        .Mem_wdata  (Mem_wdata),
        .Mem_write  (Mem_write),
        .Busy       (Busy),
        .Done       (Done),
        .Err        (Err),
        .Max_out    (Max_out),
        .Min_out    (Min_out),
        .Avg_out    (Avg_out)
    );

    logic [7:0] mem     [256];
    logic [7:0] snap    [256];
    logic [7:0] exp_mem [256];
    logic [7:0] ref_mem [256];

    assign Mem_rdata = mem[Mem_addr];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks;
    int failures;
    int done_cnt;

    always @(negedge CLK) if (Done === 1'b1) done_cnt++;

    typedef struct packed {
        logic [7:0] addr;
        logic       we;
        logic [7:0] wd;
    } cyc_t;

    typedef struct packed {
        logic [7:0]       base;
        logic [7:0]       res;
        logic [7:0]       n;
        logic [0:7][7:0]  el;
        logic [7:0]       mx;
        logic [7:0]       mn;
        logic [7:0]       av;
        logic             er;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic cyc_t mk(input logic [7:0] a, input logic w, input logic [7:0] d);
        cyc_t c;
        c.addr = a;
        c.we   = w;
        c.wd   = d;
        return c;
    endfunction

    // Runs one list: the model predicts results, the per-cycle memory-port trace and final memory.
    task automatic run(input string tag, input logic [7:0] base, input logic [7:0] res,
                       input bit extra_start,
                       output logic [7:0] mx, output logic [7:0] mn, output logic [7:0] av,
                       output bit er);
        cyc_t exp_q[$];
        cyc_t got_q[$];
        int   n;
        int   sum;
        int   cyc;
        int   bad;
        int   ndiff;
        bit   timeout;
        logic [7:0] v;

        snap = mem;
        n   = int'(mem[base]);
        mx  = 8'd0;
        mn  = (n == 0) ? 8'd0 : 8'd255;
        sum = 0;
        er  = (n == 0);
        for (int i = 0; i < n; i++) begin
            v = snap[8'(int'(base) + 1 + i)];
            if (v > mx) mx = v;
            if (v < mn) mn = v;
            sum += int'(v);
        end
        av = (n == 0) ? 8'd0 : 8'(sum / n);

        exp_mem = snap;
        exp_q.push_back(mk(base, 1'b0, 8'h00));
        if (n > 0) begin
            for (int i = 0; i < n; i++) exp_q.push_back(mk(8'(int'(base) + 1 + i), 1'b0, 8'h00));
            for (int i = 0; i < 16; i++) exp_q.push_back(mk(8'h00, 1'b0, 8'h00));
            if (WB) begin
                exp_q.push_back(mk(res, 1'b1, mx));
                exp_q.push_back(mk(8'(res + 8'd1), 1'b1, mn));
                exp_q.push_back(mk(8'(res + 8'd2), 1'b1, av));
                exp_mem[res]               = mx;
                exp_mem[8'(res + 8'd1)]    = mn;
                exp_mem[8'(res + 8'd2)]    = av;
            end
        end
        exp_q.push_back(mk(8'h00, 1'b0, 8'h00));

        @(negedge CLK);
        Base_addr   = base;
        Result_addr = res;
        Start       = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        check({tag, " busy"}, Busy, 1);

        cyc     = 0;
        timeout = 1'b1;
        while (cyc < 400) begin
            got_q.push_back(mk(Mem_addr, Mem_write, Mem_wdata));
            if (Mem_write === 1'b1) mem[Mem_addr] = Mem_wdata;
            if (Done === 1'b1) begin
                timeout = 1'b0;
                break;
            end
            Start = extra_start && (cyc == 2);
            @(negedge CLK);
            cyc++;
        end
        Start = 1'b0;

        check({tag, " timeout"}, timeout, 0);
        check({tag, " latency"}, got_q.size() - 1, exp_q.size() - 1);
        bad = -1;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (bad < 0 && got_q[i] !== exp_q[i]) begin
                bad = i;
                $display("  trace %s cycle %0d: got addr=%0h we=%0b wd=%0h, want addr=%0h we=%0b wd=%0h",
                         tag, i, got_q[i].addr, got_q[i].we, got_q[i].wd,
                         exp_q[i].addr, exp_q[i].we, exp_q[i].wd);
            end
        end
        check({tag, " trace_first_bad_cycle"}, bad, -1);

        ndiff = 0;
        for (int a = 0; a < 256; a++) if (mem[a] !== exp_mem[a]) ndiff++;
        check({tag, " mem_diffs"}, ndiff, 0);

        check({tag, " max"}, Max_out, mx);
        check({tag, " min"}, Min_out, mn);
        check({tag, " avg"}, Avg_out, av);
        check({tag, " err"}, Err, er);
    endtask

    vec_t       vecs [5];
    logic [7:0] mx, mn, av;
    bit         er;
    int         d0;
    int         ndiff;

    initial begin
        RST_n       = 1'b0;
        Start       = 1'b0;
        Base_addr   = 8'h00;
        Result_addr = 8'h00;
        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);

        vecs[0] = '{base:8'h10, res:8'hF0, n:8'd6, el:{8'd7, 8'd8, 8'd2, 8'd3, 8'd5, 8'd9, 8'd0, 8'd0},
                    mx:8'd9, mn:8'd2, av:8'd5, er:1'b0};
        vecs[1] = '{base:8'h40, res:8'h80, n:8'd0, el:'0, mx:8'd0, mn:8'd0, av:8'd0, er:1'b1};
        vecs[2] = '{base:8'hFD, res:8'hFE, n:8'd3, el:{8'd200, 8'd1, 8'd50, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                    mx:8'd200, mn:8'd1, av:8'd83, er:1'b0};
        vecs[3] = '{base:8'h30, res:8'h31, n:8'd1, el:'0, mx:8'd0, mn:8'd0, av:8'd0, er:1'b0};
        vecs[4] = '{base:8'h90, res:8'h10, n:8'd2, el:{8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                    mx:8'd255, mn:8'd0, av:8'd127, er:1'b0};

        repeat (2) @(negedge CLK);
        check("reset busy",  Busy, 0);
        check("reset done",  Done, 0);
        check("reset write", Mem_write, 0);
        check("reset addr",  Mem_addr, 0);
        check("reset wdata", Mem_wdata, 0);
        check("reset outs",  {Max_out, Min_out, Avg_out}, 0);
        check("reset err",   Err, 0);
        RST_n = 1'b1;

        for (int t = 0; t < 5; t++) begin
            mem[vecs[t].base] = vecs[t].n;
            for (int j = 0; j < int'(vecs[t].n); j++)
                mem[8'(int'(vecs[t].base) + 1 + j)] = vecs[t].el[j];
            run($sformatf("vec%0d", t), vecs[t].base, vecs[t].res, 1'b0, mx, mn, av, er);
            check($sformatf("vec%0d table_max", t), Max_out, vecs[t].mx);
            check($sformatf("vec%0d table_min", t), Min_out, vecs[t].mn);
            check($sformatf("vec%0d table_avg", t), Avg_out, vecs[t].av);
            check($sformatf("vec%0d table_err", t), Err, vecs[t].er);
        end

        for (int a = 0; a < 256; a++) mem[a] = 8'hFF;
        run("full255", 8'h00, 8'h05, 1'b0, mx, mn, av, er);
        check("full255 values", {Max_out, Min_out, Avg_out}, 24'hFFFFFF);

        for (int r = 0; r < 6; r++) begin
            logic [7:0] b;
            for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
            b = 8'($urandom);
            mem[b] = 8'($urandom_range(1, 40));
            run($sformatf("rand%0d", r), b, 8'($urandom), 1'b0, mx, mn, av, er);
        end

        // Reset in the middle of a scan, then a run with a stray Start while busy
        mem[8'h10] = 8'd6;
        for (int j = 0; j < 6; j++) mem[8'h11 + j] = vecs[0].el[j];
        run("pre_reset", 8'h10, 8'hF0, 1'b0, mx, mn, av, er);
        ref_mem = mem;
        @(negedge CLK);
        Base_addr   = 8'h10;
        Result_addr = 8'hF0;
        Start       = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        repeat (3) @(negedge CLK);
        #2 RST_n = 1'b0;
        #1;
        check("midreset busy",  Busy, 0);
        check("midreset write", Mem_write, 0);
        check("midreset done",  Done, 0);
        check("midreset outs",  {Max_out, Min_out, Avg_out}, 0);
        ndiff = 0;
        for (int a = 0; a < 256; a++) if (mem[a] !== ref_mem[a]) ndiff++;
        check("midreset mem_diffs", ndiff, 0);
        @(negedge CLK);
        RST_n = 1'b1;

        d0 = done_cnt;
        run("stray_start", 8'h10, 8'hF0, 1'b1, mx, mn, av, er);
        repeat (30) @(negedge CLK);
        check("stray_start done_pulses", done_cnt - d0, 1);
        check("stray_start idle", Busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
